// File: rtl/conv_host_pkg.sv
// Shared types and constants for the CONV host-side memory block.
package conv_host_pkg;

  localparam int DW        = 20;
  localparam int IMG_DEPTH = 4096;
  localparam int L1_DEPTH  = 1024;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_ARM  = 3'd1,
    ST_RUN  = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/conv_host_bank.sv
// Single-write memory bank: combinational read port A for CONV, registered
// read port B (with enable so the dump word holds during back-pressure).
module conv_host_bank #(
  parameter  int DEPTH = 4096,
  parameter  int DW    = 20,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic          i_re_b,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b
);
  import conv_host_pkg::*;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata_b;

  // write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // registered read port B, updated only when enabled
  always_ff @(posedge i_clk) begin
    if (i_re_b) begin
      r_rdata_b <= r_mem[i_raddr_b];
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/conv_host_mem.sv
// Host-side counterpart of CONV: image load, layer memories, ready/busy handshake
// and result dump. Optional watchdog enabled by defining CONV_HOST_WDOG_EN.
module conv_host_mem #(
  parameter int          DW          = 20,
  parameter int          IMG_AW      = 12,
  parameter int          L1_AW       = 10,
  parameter logic [31:0] TIMEOUT_CYC = 32'd16777216
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ld_valid,
  input  logic [DW-1:0]     i_ld_data,
  output logic              o_ready,
  input  logic              i_busy,
  input  logic [IMG_AW-1:0] i_iaddr,
  output logic [DW-1:0]     o_idata,
  input  logic              i_cwr,
  input  logic              i_crd,
  input  logic [2:0]        i_csel,
  input  logic [11:0]       i_caddr_wr,
  input  logic [DW-1:0]     i_cdata_wr,
  input  logic [11:0]       i_caddr_rd,
  output logic [DW-1:0]     o_cdata_rd,
  output logic              o_dout_valid,
  input  logic              i_dout_ready,
  output logic [DW-1:0]     o_dout_data,
  output logic              o_dout_bank,
  output logic              o_dout_last,
  output logic              o_sel_err,
  output logic              o_timeout
);
  import conv_host_pkg::*;

  localparam logic [IMG_AW-1:0] LD_LAST   = IMG_AW'(IMG_DEPTH - 1);
  localparam logic [IMG_AW:0]   DUMP_LAST = (IMG_AW + 1)'(IMG_DEPTH + L1_DEPTH - 1);
  localparam logic [IMG_AW:0]   DUMP_END  = (IMG_AW + 1)'(IMG_DEPTH + L1_DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IMG_AW-1:0]   r_ld_cnt;
  logic [IMG_AW:0]     r_dump_addr;
  logic                r_ready;
  logic                r_dout_valid;
  logic                r_dout_bank;
  logic                r_dout_last;
  logic                r_sel_err;

  logic                w_run;
  logic                w_img_we;
  logic                w_wr_l0, w_wr_l1, w_rd_l0, w_rd_l1;
  logic                w_l0_we, w_l1_we;
  logic                w_run_err;
  logic                w_fetch;
  logic                w_dump_hs;
  logic                w_wd_hit;
  logic [DW-1:0]       w_img_rd_a, w_img_unused_rd;
  logic [DW-1:0]       w_l0_rd_a, w_l0_rd_b;
  logic [DW-1:0]       w_l1_rd_a, w_l1_rd_b;

  assign w_run    = (r_state == ST_RUN);
  assign w_img_we = (r_state == ST_LOAD) && i_ld_valid;

  // L1 accesses are legal only below its depth; upper address bits must be clear
  assign w_wr_l0 = (i_csel == CSEL_L0);
  assign w_wr_l1 = (i_csel == CSEL_L1) && (i_caddr_wr[11:L1_AW] == '0);
  assign w_rd_l0 = (i_csel == CSEL_L0);
  assign w_rd_l1 = (i_csel == CSEL_L1) && (i_caddr_rd[11:L1_AW] == '0);

  assign w_l0_we   = w_run && i_cwr && w_wr_l0;
  assign w_l1_we   = w_run && i_cwr && w_wr_l1;
  assign w_run_err = w_run && ((i_cwr && !(w_wr_l0 || w_wr_l1)) ||
                               (i_crd && !(w_rd_l0 || w_rd_l1)));

  assign w_dump_hs = r_dout_valid && i_dout_ready;
  assign w_fetch   = (r_state == ST_DUMP) && (r_dump_addr != DUMP_END) &&
                     (!r_dout_valid || i_dout_ready);

`ifdef CONV_HOST_WDOG_EN
  logic [31:0] r_wd_cnt;
  logic        r_timeout;
  logic        w_wd_run;

  assign w_wd_run = (r_state == ST_ARM) || (r_state == ST_RUN);
  assign w_wd_hit = w_wd_run && ((r_wd_cnt + 32'd1) >= TIMEOUT_CYC);

  // watchdog counter and sticky timeout flag
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wd_cnt  <= 32'd0;
      r_timeout <= 1'b0;
    end else if (w_wd_hit) begin
      r_wd_cnt  <= 32'd0;
      r_timeout <= 1'b1;
    end else if (w_wd_run) begin
      r_wd_cnt  <= r_wd_cnt + 32'd1;
    end else begin
      r_wd_cnt  <= 32'd0;
    end
  end

  assign o_timeout = r_timeout;
`else
  localparam logic [31:0] UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
  assign w_wd_hit  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: begin
        if (i_ld_valid && (r_ld_cnt == LD_LAST)) begin
          w_state_nxt = ST_ARM;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_ARM: begin
        if (w_wd_hit) begin
          w_state_nxt = ST_DUMP;
        end else if (i_busy) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_ARM;
        end
      end
      ST_RUN: begin
        // RUN is only entered with busy high, so a low busy here is its falling edge
        if (w_wd_hit || !i_busy) begin
          w_state_nxt = ST_DUMP;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DUMP: begin
        if (w_dump_hs && r_dout_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DUMP;
        end
      end
      ST_DONE: w_state_nxt = ST_LOAD;
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // state, counters, handshake flags and dump stream registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_LOAD;
      r_ld_cnt     <= '0;
      r_dump_addr  <= '0;
      r_ready      <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_bank  <= 1'b0;
      r_dout_last  <= 1'b0;
      r_sel_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_ARM);
      if (r_state == ST_DONE) begin
        r_ld_cnt <= '0;
      end else if (w_img_we) begin
        r_ld_cnt <= r_ld_cnt + IMG_AW'(1);
      end
      if (w_run_err) begin
        r_sel_err <= 1'b1;
      end
      if (r_state != ST_DUMP) begin
        r_dump_addr  <= '0;
        r_dout_valid <= 1'b0;
        r_dout_bank  <= 1'b0;
        r_dout_last  <= 1'b0;
      end else if (w_fetch) begin
        r_dump_addr  <= r_dump_addr + (IMG_AW + 1)'(1);
        r_dout_valid <= 1'b1;
        r_dout_bank  <= r_dump_addr[IMG_AW];
        r_dout_last  <= (r_dump_addr == DUMP_LAST);
      end else if (w_dump_hs) begin
        r_dout_valid <= 1'b0;
        r_dout_last  <= 1'b0;
      end
    end
  end

  conv_host_bank #(.DEPTH(IMG_DEPTH), .DW(DW)) u_img (
    .i_clk     (i_clk),
    .i_we      (w_img_we),
    .i_waddr   (r_ld_cnt),
    .i_wdata   (i_ld_data),
    .i_raddr_a (i_iaddr),
    .o_rdata_a (w_img_rd_a),
    .i_re_b    (1'b0),
    .i_raddr_b ('0),
    .o_rdata_b (w_img_unused_rd)
  );

  conv_host_bank #(.DEPTH(IMG_DEPTH), .DW(DW)) u_l0 (
    .i_clk     (i_clk),
    .i_we      (w_l0_we),
    .i_waddr   (i_caddr_wr[IMG_AW-1:0]),
    .i_wdata   (i_cdata_wr),
    .i_raddr_a (i_caddr_rd[IMG_AW-1:0]),
    .o_rdata_a (w_l0_rd_a),
    .i_re_b    (w_fetch && !r_dump_addr[IMG_AW]),
    .i_raddr_b (r_dump_addr[IMG_AW-1:0]),
    .o_rdata_b (w_l0_rd_b)
  );

  conv_host_bank #(.DEPTH(L1_DEPTH), .DW(DW)) u_l1 (
    .i_clk     (i_clk),
    .i_we      (w_l1_we),
    .i_waddr   (i_caddr_wr[L1_AW-1:0]),
    .i_wdata   (i_cdata_wr),
    .i_raddr_a (i_caddr_rd[L1_AW-1:0]),
    .o_rdata_a (w_l1_rd_a),
    .i_re_b    (w_fetch && r_dump_addr[IMG_AW]),
    .i_raddr_b (r_dump_addr[L1_AW-1:0]),
    .o_rdata_b (w_l1_rd_b)
  );

  // CONV-side combinational read data
  always_comb begin
    o_idata    = '0;
    o_cdata_rd = '0;
    if (w_run) begin
      o_idata = w_img_rd_a;
    end else begin
      o_idata = '0;
    end
    if (w_run && i_crd && w_rd_l0) begin
      o_cdata_rd = w_l0_rd_a;
    end else if (w_run && i_crd && w_rd_l1) begin
      o_cdata_rd = w_l1_rd_a;
    end else begin
      o_cdata_rd = '0;
    end
  end

  // dump data select; zero while no beat is presented
  always_comb begin
    o_dout_data = '0;
    if (r_dout_valid) begin
      if (r_dout_bank) begin
        o_dout_data = w_l1_rd_b;
      end else begin
        o_dout_data = w_l0_rd_b;
      end
    end else begin
      o_dout_data = '0;
    end
  end

  assign o_ready      = r_ready;
  assign o_dout_valid = r_dout_valid;
  assign o_dout_bank  = r_dout_valid && r_dout_bank;
  assign o_dout_last  = r_dout_valid && r_dout_last;
  assign o_sel_err    = r_sel_err;

endmodule

// File: tb/tb_conv_host_mem.sv
// Directed self-checking bench for conv_host_mem (default build, watchdog absent).
module tb_conv_host_mem;
  localparam int DW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, ld_valid, busy, cwr, crd, dout_ready;
  logic [DW-1:0] ld_data, cdata_wr;
  logic [11:0]   iaddr, caddr_wr, caddr_rd;
  logic [2:0]    csel;
  logic          ready, dout_valid, dout_bank, dout_last, sel_err, timeout;
  logic [DW-1:0] idata, cdata_rd, dout_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_l0 [4096];
  logic [DW-1:0] exp_l1 [1024];

  conv_host_mem dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_ld_valid   (ld_valid),
    .i_ld_data    (ld_data),
    .o_ready      (ready),
    .i_busy       (busy),
    .i_iaddr      (iaddr),
    .o_idata      (idata),
    .i_cwr        (cwr),
    .i_crd        (crd),
    .i_csel       (csel),
    .i_caddr_wr   (caddr_wr),
    .i_cdata_wr   (cdata_wr),
    .i_caddr_rd   (caddr_rd),
    .o_cdata_rd   (cdata_rd),
    .o_dout_valid (dout_valid),
    .i_dout_ready (dout_ready),
    .o_dout_data  (dout_data),
    .o_dout_bank  (dout_bank),
    .o_dout_last  (dout_last),
    .o_sel_err    (sel_err),
    .o_timeout    (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] beat_word(input logic bank, input logic last, input logic [DW-1:0] d);
    return {9'd0, 1'b1, bank, last, d};
  endfunction

  logic [31:0] obs_w, held_w;
  logic        stalled;
  int          beat, cyc;

  initial begin
    reset = 1'b1; ld_valid = 1'b0; ld_data = 20'd0; busy = 1'b0; iaddr = 12'd0;
    cwr = 1'b0; crd = 1'b0; csel = 3'd0; caddr_wr = 12'd0; cdata_wr = 20'd0;
    caddr_rd = 12'd0; dout_ready = 1'b0;
    tick(); tick();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_data", {12'd0, dout_data}, 32'd0);
    chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_idata", {12'd0, idata}, 32'd0);
    reset = 1'b0;

    // image load: value = address
    for (int i = 0; i < 4096; i++) begin
      ld_valid = 1'b1;
      ld_data  = DW'(i);
      tick();
      if (i == 4094) chk("ready_early", {31'd0, ready}, 32'd0);
    end
    chk("ready_after_load", {31'd0, ready}, 32'd1);
    ld_data = 20'hFFFFF;      // extra word in ARM must be ignored
    tick();
    ld_valid = 1'b0;
    tick(); tick();
    chk("ready_hold", {31'd0, ready}, 32'd1);
    chk("idata_outside_run", {12'd0, idata}, 32'd0);
    busy = 1'b1;
    tick();
    chk("ready_drop", {31'd0, ready}, 32'd0);

    // image fetch
    iaddr = 12'h0A5; #1;
    chk("idata_0a5", {12'd0, idata}, 32'h000A5);
    iaddr = 12'h000; #1;
    chk("idata_0_not_overwritten", {12'd0, idata}, 32'h00000);
    iaddr = 12'hFFF; #1;
    chk("idata_fff", {12'd0, idata}, 32'h00FFF);

    // fill both layers
    cwr = 1'b1; csel = 3'b001;
    for (int a = 0; a < 4096; a++) begin
      caddr_wr = 12'(a); cdata_wr = DW'(32'h50000 + a); exp_l0[a] = cdata_wr;
      tick();
    end
    csel = 3'b011;
    for (int a = 0; a < 1024; a++) begin
      caddr_wr = 12'(a); cdata_wr = DW'(32'hA0000 + a); exp_l1[a] = cdata_wr;
      tick();
    end

    // write then read L0[7]
    csel = 3'b001; caddr_wr = 12'd7; cdata_wr = 20'h12345; exp_l0[7] = 20'h12345;
    tick();
    cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd7; #1;
    chk("l0_rd7", {12'd0, cdata_rd}, 32'h12345);
    caddr_rd = 12'd100; #1;
    chk("l0_rd100", {12'd0, cdata_rd}, 32'h50064);
    crd = 1'b0; #1;
    chk("crd_low_zero", {12'd0, cdata_rd}, 32'd0);

    // read-before-write on L1[3]
    csel = 3'b011; cwr = 1'b1; caddr_wr = 12'd3; cdata_wr = 20'h00001;
    tick();
    cdata_wr = 20'h00002; crd = 1'b1; caddr_rd = 12'd3; #1;
    chk("rbw_old", {12'd0, cdata_rd}, 32'h00001);
    tick();
    cwr = 1'b0; exp_l1[3] = 20'h00002; #1;
    chk("rbw_new", {12'd0, cdata_rd}, 32'h00002);
    crd = 1'b0;

    // illegal selects
    chk("sel_err_clean", {31'd0, sel_err}, 32'd0);
    cwr = 1'b1; csel = 3'b010; caddr_wr = 12'd5; cdata_wr = 20'h77777;
    tick();
    chk("sel_err_csel", {31'd0, sel_err}, 32'd1);
    csel = 3'b011; caddr_wr = 12'h400; cdata_wr = 20'h66666;
    tick();
    cwr = 1'b0; crd = 1'b1; csel = 3'b001; caddr_rd = 12'd5; #1;
    chk("l0_5_kept", {12'd0, cdata_rd}, {12'd0, exp_l0[5]});
    csel = 3'b011; caddr_rd = 12'd0; #1;
    chk("l1_0_kept", {12'd0, cdata_rd}, {12'd0, exp_l1[0]});
    caddr_rd = 12'h400; #1;
    chk("l1_oob_rd_zero", {12'd0, cdata_rd}, 32'd0);
    csel = 3'b111; caddr_rd = 12'd0; #1;
    chk("bad_csel_rd_zero", {12'd0, cdata_rd}, 32'd0);
    crd = 1'b0;
    tick();
    chk("sel_err_sticky", {31'd0, sel_err}, 32'd1);

    // busy falls: full dump with back-pressure
    busy = 1'b0;
    tick();
    beat = 0; cyc = 0; stalled = 1'b0; held_w = 32'd0;
    while (beat < 5120 && cyc < 20000) begin
      dout_ready = (cyc % 3 != 1);
      obs_w = {9'd0, dout_valid, dout_bank, dout_last, dout_data};
      if (stalled) chk("stall_hold", obs_w, held_w);
      if (cyc == 40) begin
        cwr = 1'b1; csel = 3'b001; caddr_wr = 12'hFFF; cdata_wr = 20'hDEAD0;
        crd = 1'b1; caddr_rd = 12'hFFF; #1;
        chk("dump_crd_zero", {12'd0, cdata_rd}, 32'd0);
      end else begin
        cwr = 1'b0; crd = 1'b0;
      end
      if (dout_valid && dout_ready) begin
        if (beat < 4096) chk($sformatf("dump_beat%0d", beat), obs_w, beat_word(1'b0, 1'b0, exp_l0[beat]));
        else chk($sformatf("dump_beat%0d", beat), obs_w, beat_word(1'b1, beat == 5119, exp_l1[beat-4096]));
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = dout_valid;
        held_w  = obs_w;
      end
      tick();
      cyc++;
    end
    chk("dump_count", 32'(beat), 32'd5120);
    chk("done_valid_low", {31'd0, dout_valid}, 32'd0);
    tick();
    chk("load_again_ready_low", {31'd0, ready}, 32'd0);

    // second image; layer memories keep old contents
    for (int i = 0; i < 4096; i++) begin
      ld_valid = 1'b1; ld_data = DW'(32'h30000 + i);
      tick();
    end
    ld_valid = 1'b0;
    chk("ready_second_load", {31'd0, ready}, 32'd1);
    busy = 1'b1;
    tick();
    iaddr = 12'h0A5; #1;
    chk("idata_second_image", {12'd0, idata}, 32'h300A5);
    cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd0; cdata_wr = 20'hABCDE; exp_l0[0] = 20'hABCDE;
    tick();
    cwr = 1'b0;
    chk("sel_err_still_set", {31'd0, sel_err}, 32'd1);
    busy = 1'b0;
    tick();
    dout_ready = 1'b1; beat = 0; cyc = 0;
    while (beat < 100 && cyc < 1000) begin
      if (dout_valid) begin
        chk($sformatf("dump2_beat%0d", beat), {9'd0, dout_valid, dout_bank, dout_last, dout_data},
            beat_word(1'b0, 1'b0, exp_l0[beat]));
        beat++;
      end
      tick();
      cyc++;
    end
    chk("dump2_reached_100", 32'(beat), 32'd100);
    chk("beat100_valid", {31'd0, dout_valid}, 32'd1);

    // reset during beat 100
    reset = 1'b1; crd = 1'b1; csel = 3'b001; caddr_rd = 12'd7;
    tick();
    chk("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("mid_rst_data", {12'd0, dout_data}, 32'd0);
    chk("mid_rst_bank_last", {30'd0, dout_bank, dout_last}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_sel_err", {31'd0, sel_err}, 32'd0);
    chk("mid_rst_timeout", {31'd0, timeout}, 32'd0);
    chk("mid_rst_idata", {12'd0, idata}, 32'd0);
    chk("mid_rst_cdata_rd", {12'd0, cdata_rd}, 32'd0);
    reset = 1'b0; crd = 1'b0;
    tick(); tick();
    chk("post_rst_valid", {31'd0, dout_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
